// File: rtl/alu_share_ctrl.sv
// Two-requester front end for one shared combinational ALU: round-robin grant,
// a one-entry response register with backpressure, flush and an overflow counter.
module alu_share_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req0_aluc,
  input  logic [3:0]       req1_aluc,
  input  logic             req0_trap,
  input  logic             req1_trap,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_aluc,
  input  logic [31:0]      alu_r,
  input  logic             alu_z,
  input  logic             alu_v,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [31:0]      rsp_r,
  output logic             rsp_z,
  output logic             rsp_ov,
  input  logic             rsp_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] ov_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e             state_q;
  logic               last_q;
  logic               rsp_id_q, rsp_z_q, rsp_ov_q;
  logic [31:0]        rsp_r_q;
  logic [CNT_W-1:0]   ov_cnt_q;

  logic [1:0][31:0]   req_a, req_b;
  logic [1:0][3:0]    req_aluc;
  logic [1:0]         req_trap;

  logic can_accept, gnt_vld, gnt_idx, sel, ov_inc;

  assign req_a    = {req1_a, req0_a};
  assign req_b    = {req1_b, req0_b};
  assign req_aluc = {req1_aluc, req0_aluc};
  assign req_trap = {req1_trap, req0_trap};

  always_comb begin
    can_accept = !flush && (state_q == EMPTY || rsp_ready);
    gnt_vld    = can_accept && (req0_valid || req1_valid);
    // Under contention the requester not served last wins; otherwise the lone one.
    gnt_idx    = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    sel        = gnt_vld ? gnt_idx : last_q;
    ov_inc     = (state_q == FULL) && rsp_ov_q && rsp_ready && !flush;
  end

  assign req0_ready = gnt_vld && !gnt_idx;
  assign req1_ready = gnt_vld &&  gnt_idx;

  assign alu_a    = req_a[sel];
  assign alu_b    = req_b[sel];
  assign alu_aluc = req_aluc[sel];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= EMPTY;
      last_q   <= 1'b1;
      rsp_id_q <= 1'b0;
      rsp_r_q  <= '0;
      rsp_z_q  <= 1'b0;
      rsp_ov_q <= 1'b0;
      ov_cnt_q <= '0;
    end else begin
      if (ov_inc && ov_cnt_q != {CNT_W{1'b1}})
        ov_cnt_q <= ov_cnt_q + 1'b1;
      if (gnt_vld) begin
        state_q  <= FULL;
        last_q   <= gnt_idx;
        rsp_id_q <= gnt_idx;
        rsp_r_q  <= alu_r;
        rsp_z_q  <= alu_z;
        rsp_ov_q <= alu_v && req_trap[gnt_idx];
      end else if (flush || rsp_ready) begin
        state_q  <= EMPTY;
      end
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_ov    = rsp_ov_q;
  assign ov_cnt    = ov_cnt_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares on each consumption.
module tb_alu_share_ctrl;

  localparam int CNT_W = 2;

  logic             clk, clrn;
  logic             req0_valid, req1_valid;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_aluc, req1_aluc;
  logic             req0_trap, req1_trap;
  logic             req0_ready, req1_ready;
  logic [31:0]      alu_a, alu_b, alu_r;
  logic [3:0]       alu_aluc;
  logic             alu_z, alu_v;
  logic             rsp_valid, rsp_id, rsp_z, rsp_ov, rsp_ready, flush;
  logic [31:0]      rsp_r;
  logic [CNT_W-1:0] ov_cnt;

  typedef struct packed {
    logic        id;
    logic [31:0] r;
    logic        z;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   errs   = 0;
  int   checks = 0;

  alu_share_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_aluc(req0_aluc), .req1_aluc(req1_aluc),
    .req0_trap(req0_trap), .req1_trap(req1_trap),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_r(alu_r), .alu_z(alu_z), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_z(rsp_z),
    .rsp_ov(rsp_ov), .rsp_ready(rsp_ready), .flush(flush), .ov_cnt(ov_cnt)
  );

  // External shared ALU: add for aluc 0000, subtract otherwise.
  always_comb begin
    alu_r = (alu_aluc == 4'b0000) ? alu_a + alu_b : alu_a - alu_b;
    alu_z = (alu_r == 32'd0);
    alu_v = (alu_aluc == 4'b0000) ? (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31])
                                  : (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (clrn && rsp_valid && (rsp_ready || flush)) begin
      if (flush) begin
        if (sb.size() > 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL rsp_unexpected: got id=%0d r=%0h with empty scoreboard", rsp_id, rsp_r);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp", {rsp_id, rsp_r, rsp_z, rsp_ov}, {e.id, e.r, e.z, e.ov});
      end
    end
  end

  // One cycle: drive after the edge, check the grant, record the expected response.
  task automatic cyc(input logic v0, input logic [31:0] a0, b0, input logic t0,
                     input logic v1, input logic [31:0] a1, b1, input logic t1,
                     input logic rr, fl, input int eg,
                     input logic [31:0] er, input logic ez, eov);
    @(posedge clk); #1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_trap = t0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_trap = t1;
    rsp_ready = rr; flush = fl;
    #1;
    check("req0_ready", {63'd0, req0_ready}, {63'd0, eg == 1});
    check("req1_ready", {63'd0, req1_ready}, {63'd0, eg == 2});
    if (eg != 0) sb.push_back('{id: (eg == 2), r: er, z: ez, ov: eov});
  endtask

  task automatic idle(input logic rr);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, rr, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_pulse;
    @(posedge clk); #1;
    clrn = 1'b0;
    #1;
    check("rst_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_ovcnt", {62'd0, ov_cnt}, 64'd0);
    sb.delete();
    @(negedge clk);
    clrn = 1'b1;
  endtask

  initial begin
    clrn = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    req0_aluc = 4'b0000; req1_aluc = 4'b0000; req0_trap = 0; req1_trap = 0;
    #3;
    check("reset_state", {rsp_valid, rsp_id, rsp_r, rsp_z, rsp_ov, ov_cnt}, 64'd0);
    @(negedge clk); clrn = 1'b1;

    // Single request: 7+5
    cyc(1, 7, 5, 0, 0, 0, 0, 0, 1, 0, 1, 32'd12, 0, 0);
    idle(1);

    // Contention from reset: 0,1,0,1 without bubbles
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 1, 0, 1, 10, 3, 0, 1, 0, (i % 2 == 0) ? 1 : 2,
          (i % 2 == 0) ? 32'd2 : 32'd13, 0, 0);
      if (i > 0) check("no_bubble", {63'd0, rsp_valid}, 64'd1);
    end
    idle(1);

    // Overflow with trap, then without
    cyc(0, 0, 0, 0, 1, 32'h7FFF_FFFF, 1, 1, 1, 0, 2, 32'h8000_0000, 0, 1);
    cyc(0, 0, 0, 0, 0, 32'h7FFF_FFFF, 1, 1, 1, 0, 0, 0, 0, 0);
    check("alu_a_lastgrant", {32'd0, alu_a}, {32'd0, 32'h7FFF_FFFF});
    cyc(0, 0, 0, 0, 1, 32'h7FFF_FFFF, 1, 0, 1, 0, 2, 32'h8000_0000, 0, 0);
    check("ovcnt_trap", {62'd0, ov_cnt}, 64'd1);
    idle(1);
    idle(1);
    check("ovcnt_notrap", {62'd0, ov_cnt}, 64'd1);

    // Backpressure
    cyc(1, 3, 4, 0, 0, 0, 0, 0, 1, 0, 1, 32'd7, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 20, 22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("bp_hold", {31'd0, rsp_valid, rsp_r}, {31'd0, 1'b1, 32'd7});
    end
    cyc(1, 20, 22, 0, 0, 0, 0, 0, 1, 0, 1, 32'd42, 0, 0);
    idle(1);

    // Zero result
    cyc(0, 0, 0, 0, 1, 5, 32'hFFFF_FFFB, 0, 1, 0, 2, 32'd0, 1, 0);
    idle(1);

    // Flush while holding a trapped overflow
    cyc(1, 32'h7FFF_FFFF, 1, 1, 0, 0, 0, 0, 1, 0, 1, 32'h8000_0000, 0, 1);
    cyc(1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0);
    idle(1);
    check("flush_empty", {63'd0, rsp_valid}, 64'd0);
    check("flush_ovcnt", {62'd0, ov_cnt}, 64'd1);

    // Saturation at CNT_W=2
    reset_pulse();
    for (int i = 0; i < 4; i++)
      cyc(1, 32'h7FFF_FFFF, 1, 1, 0, 0, 0, 0, 1, 0, 1, 32'h8000_0000, 0, 1);
    idle(1);
    idle(1);
    check("ovcnt_sat", {62'd0, ov_cnt}, 64'd3);

    // Asynchronous reset while FULL, then contention restarts at requester 0
    cyc(1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1, 32'd3, 0, 0);
    idle(0);
    check("full_before_rst", {63'd0, rsp_valid}, 64'd1);
    #1; clrn = 1'b0;
    #1;
    check("async_valid", {63'd0, rsp_valid}, 64'd0);
    check("async_ovcnt", {62'd0, ov_cnt}, 64'd0);
    sb.delete();
    @(negedge clk); clrn = 1'b1;
    cyc(1, 4, 4, 0, 1, 9, 9, 0, 1, 0, 1, 32'd8, 0, 0);
    idle(1);
    @(negedge clk); #1;
    check("sb_drained", sb.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
